// File: rtl/ucsbece154a_datapath_pkg.sv
// Shared encodings for the multicycle RV32I controller/datapath pair:
// ALU operation, immediate format, result select, ALU operand selects,
// memory address select, the reset NOP instruction and the extend helper.
package ucsbece154a_datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_A     = 2'b10,
    SRCA_ZERO  = 2'b11
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_WD   = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10,
    SRCB_ZERO = 2'b11
  } alu_src_b_e;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // addi x0,x0,0 -- the instruction register holds this out of reset
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Immediate generation; unknown formats fall back to the I-type layout.
  function automatic logic [31:0] extend_imm(input logic [31:0] instr, input logic [2:0] imm_src);
    logic [31:0] imm;
    case (imm_src_e'(imm_src))
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/ucsbece154a_rf.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero. Contents are not reset.
// Optional debug read port enabled by defining UCSBECE154A_RF_DEBUG_EN.
module ucsbece154a_rf (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
`ifdef UCSBECE154A_RF_DEBUG_EN
  ,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
`endif
);

  logic [31:0] regs_r [32];

  // Write port; writes aimed at x0 are dropped so it always reads zero
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      regs_r[wa] <= wd;
    end
  end

  // Asynchronous read ports with x0 forced to zero
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (ra1 != 5'd0) begin
      rd1 = regs_r[ra1];
    end else begin
      rd1 = 32'd0;
    end
    if (ra2 != 5'd0) begin
      rd2 = regs_r[ra2];
    end else begin
      rd2 = 32'd0;
    end
  end

`ifdef UCSBECE154A_RF_DEBUG_EN
  // Debug read port, same x0 rule as the functional ports
  always_comb begin
    dbg_data_o = 32'd0;
    if (dbg_addr_i != 5'd0) begin
      dbg_data_o = regs_r[dbg_addr_i];
    end else begin
      dbg_data_o = 32'd0;
    end
  end
`endif

endmodule

// File: rtl/ucsbece154a_datapath.sv
// Multicycle RV32I datapath: PC/OldPC/Instr/Data/A/WriteData/ALUOut
// registers, register file, extend unit and ALU. Driven every cycle by the
// controller FSM's registered control outputs.
// Optional macro UCSBECE154A_RF_DEBUG_EN adds a register-file debug read port.
module ucsbece154a_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite_i,
  input  logic        IRWrite_i,
  input  logic        RegWrite_i,
  input  logic        AdrSrc_i,
  input  logic [1:0]  ALUSrcA_i,
  input  logic [1:0]  ALUSrcB_i,
  input  logic [1:0]  ResultSrc_i,
  input  logic [2:0]  ALUControl_i,
  input  logic [2:0]  ImmSrc_i,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_o,
  output logic        zero_o,
  output logic [31:0] a_o,
  output logic [31:0] wd_o,
  input  logic [31:0] rd_i
`ifdef UCSBECE154A_RF_DEBUG_EN
  ,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
`endif
);

  import ucsbece154a_datapath_pkg::*;

  logic [31:0] pc_r;
  logic [31:0] old_pc_r;
  logic [31:0] instr_r;
  logic [31:0] data_r;
  logic [31:0] a_r;
  logic [31:0] write_data_r;
  logic [31:0] alu_out_r;

  logic [31:0] rf_rd1_s;
  logic [31:0] rf_rd2_s;
  logic [31:0] imm_ext_s;
  logic [31:0] src_a_s;
  logic [31:0] src_b_s;
  logic [31:0] alu_result_s;
  logic [31:0] result_s;
  logic        rf_we_s;

  // A reset edge must never commit a register-file write
  assign rf_we_s = RegWrite_i & ~reset;

  ucsbece154a_rf u_rf (
    .clk        (clk),
    .we         (rf_we_s),
    .wa         (instr_r[11:7]),
    .wd         (result_s),
    .ra1        (instr_r[19:15]),
    .ra2        (instr_r[24:20]),
    .rd1        (rf_rd1_s),
    .rd2        (rf_rd2_s)
`ifdef UCSBECE154A_RF_DEBUG_EN
    ,
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
`endif
  );

  assign imm_ext_s = extend_imm(instr_r, ImmSrc_i);

  // ALU operand selection
  always_comb begin
    src_a_s = 32'd0;
    src_b_s = 32'd0;
    case (alu_src_a_e'(ALUSrcA_i))
      SRCA_PC:    src_a_s = pc_r;
      SRCA_OLDPC: src_a_s = old_pc_r;
      SRCA_A:     src_a_s = a_r;
      default:    src_a_s = 32'd0;
    endcase
    case (alu_src_b_e'(ALUSrcB_i))
      SRCB_WD:   src_b_s = write_data_r;
      SRCB_IMM:  src_b_s = imm_ext_s;
      SRCB_FOUR: src_b_s = 32'd4;
      default:   src_b_s = 32'd0;
    endcase
  end

  // ALU: wraparound arithmetic, signed set-less-than, unknown codes add
  always_comb begin
    alu_result_s = 32'd0;
    case (alu_ctrl_e'(ALUControl_i))
      ALU_SUB: alu_result_s = src_a_s - src_b_s;
      ALU_AND: alu_result_s = src_a_s & src_b_s;
      ALU_OR:  alu_result_s = src_a_s | src_b_s;
      ALU_SLT: alu_result_s = {31'd0, ($signed(src_a_s) < $signed(src_b_s))};
      default: alu_result_s = src_a_s + src_b_s;
    endcase
  end

  // Result selection feeding PC, register file and memory address
  always_comb begin
    result_s = 32'd0;
    case (result_src_e'(ResultSrc_i))
      RES_ALUOUT:    result_s = alu_out_r;
      RES_DATA:      result_s = data_r;
      RES_ALURESULT: result_s = alu_result_s;
      default:       result_s = imm_ext_s;
    endcase
  end

  // Nonarchitectural state; OldPC samples PC before any same-edge PC update
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      old_pc_r     <= RESET_PC;
      instr_r      <= INSTR_NOP;
      data_r       <= 32'd0;
      a_r          <= 32'd0;
      write_data_r <= 32'd0;
      alu_out_r    <= 32'd0;
    end else begin
      if (PCWrite_i) begin
        pc_r <= result_s;
      end
      if (IRWrite_i) begin
        instr_r  <= rd_i;
        old_pc_r <= pc_r;
      end
      data_r       <= rd_i;
      a_r          <= rf_rd1_s;
      write_data_r <= rf_rd2_s;
      alu_out_r    <= alu_result_s;
    end
  end

  assign op_o     = instr_r[6:0];
  assign funct3_o = instr_r[14:12];
  assign funct7_o = instr_r[30];
  assign zero_o   = (alu_result_s == 32'd0);
  assign a_o      = (AdrSrc_i == ADR_RESULT) ? result_s : pc_r;
  assign wd_o     = write_data_r;

endmodule

// File: tb/tb_ucsbece154a_datapath.sv
// Self-checking bench for ucsbece154a_datapath: directed instruction
// sequences plus randomized control/data against a reference model.
// Define UCSBECE154A_RF_DEBUG_EN to also exercise the debug read port.
module tb_ucsbece154a_datapath;

  localparam logic [31:0] RST_PC = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcw, irw, rw, adr;
  logic [1:0]  asa, asb, rs;
  logic [2:0]  ctl, imm;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_o, zero_o;
  logic [31:0] a_o, wd_o, rd_i;
`ifdef UCSBECE154A_RF_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_oldpc, m_instr, m_data, m_a, m_wd, m_aluout;
  logic [31:0] m_rf [32];

  ucsbece154a_datapath #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .PCWrite_i(pcw), .IRWrite_i(irw), .RegWrite_i(rw),
    .AdrSrc_i(adr), .ALUSrcA_i(asa), .ALUSrcB_i(asb), .ResultSrc_i(rs),
    .ALUControl_i(ctl), .ImmSrc_i(imm), .op_o(op_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .zero_o(zero_o), .a_o(a_o), .wd_o(wd_o), .rd_i(rd_i)
`ifdef UCSBECE154A_RF_DEBUG_EN
    , .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_imm(input logic [31:0] x, input logic [2:0] sel);
    case (sel)
      3'd1:    return {{20{x[31]}}, x[31:25], x[11:7]};
      3'd2:    return {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
      3'd3:    return {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
      3'd4:    return {x[31:12], 12'h000};
      default: return {{20{x[31]}}, x[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] p, input logic [31:0] q, input logic [2:0] c);
    case (c)
      3'd1:    return p - q;
      3'd2:    return p & q;
      3'd3:    return p | q;
      3'd5:    return ($signed(p) < $signed(q)) ? 32'd1 : 32'd0;
      default: return p + q;
    endcase
  endfunction

  // Model's combinational view: ALU result, Result and memory address
  task automatic ref_eval(output logic [31:0] alu_v, output logic [31:0] res_v, output logic [31:0] adr_v);
    logic [31:0] sa, sb, iv;
    iv = ref_imm(m_instr, imm);
    sa = (asa == 2'd0) ? m_pc : (asa == 2'd1) ? m_oldpc : (asa == 2'd2) ? m_a : 32'd0;
    sb = (asb == 2'd0) ? m_wd : (asb == 2'd1) ? iv : (asb == 2'd2) ? 32'd4 : 32'd0;
    alu_v = ref_alu(sa, sb, ctl);
    res_v = (rs == 2'd0) ? m_aluout : (rs == 2'd1) ? m_data : (rs == 2'd2) ? alu_v : iv;
    adr_v = adr ? res_v : m_pc;
  endtask

  // One clock edge: DUT and model advance together
  task automatic tick();
    logic [31:0] alu_v, res_v, adr_v;
    logic [31:0] n_a, n_wd;
    ref_eval(alu_v, res_v, adr_v);
    n_a  = m_rf[m_instr[19:15]];
    n_wd = m_rf[m_instr[24:20]];
    @(posedge clk);
    if (reset) begin
      m_pc = RST_PC; m_oldpc = RST_PC; m_instr = 32'h0000_0013;
      m_data = 32'd0; m_a = 32'd0; m_wd = 32'd0; m_aluout = 32'd0;
    end else begin
      if (rw && m_instr[11:7] != 5'd0) m_rf[m_instr[11:7]] = res_v;
      if (irw) begin m_oldpc = m_pc; m_instr = rd_i; end
      if (pcw) m_pc = res_v;
      m_data = rd_i; m_a = n_a; m_wd = n_wd; m_aluout = alu_v;
    end
    #1;
  endtask

  task automatic set_ctl(input logic p, input logic i, input logic w, input logic ad,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] r,
                         input logic [2:0] c, input logic [2:0] im);
    pcw = p; irw = i; rw = w; adr = ad; asa = sa; asb = sb; rs = r; ctl = c; imm = im;
  endtask

  // Fetch: Instr <= word, PC <= PC + 4 through the ALU
  task automatic fetch(input logic [31:0] word);
    rd_i = word;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_i = 32'd0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0);
    tick();
    tick();
    reset = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", a_o, RST_PC); end
    checks++; if (op_o !== 7'h13 || funct3_o !== 3'd0) begin errors++; $display("FAIL reset_instr: got op=%h f3=%h expected op=13 f3=0", op_o, funct3_o); end
    checks++; if (wd_o !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h expected 0", wd_o); end
    adr = 1'b1;
    #1;
    checks++; if (a_o !== 32'd0) begin errors++; $display("FAIL reset_aluout: got %h expected 0", a_o); end
  endtask

  task automatic test_fetch();
    rd_i = 32'h0050_0093;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'h0001_0000) begin errors++; $display("FAIL fetch_addr: got %h expected 00010000", a_o); end
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 2'd2, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'h0001_0000) begin errors++; $display("FAIL fetch_oldpc: got %h expected 00010000", a_o); end
    adr = 1'b0;
    #1;
    checks++; if (a_o !== 32'h0001_0004) begin errors++; $display("FAIL fetch_pc: got %h expected 00010004", a_o); end
    checks++; if (op_o !== 7'h13 || funct3_o !== 3'd0) begin errors++; $display("FAIL fetch_op: got %h expected 13", op_o); end
  endtask

  task automatic test_addi_x0();
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 2'd2, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'd5) begin errors++; $display("FAIL addi_exec: got %h expected 5", a_o); end
    tick();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'd5) begin errors++; $display("FAIL addi_wb: got %h expected 5", a_o); end
    tick();
    fetch(32'h0070_0013);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'd7) begin errors++; $display("FAIL x0_result: got %h expected 7", a_o); end
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 2'd2, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'd0) begin errors++; $display("FAIL x0_read: got %h expected 0", a_o); end
  endtask

  task automatic test_branch();
    fetch(32'hFE10_8CE3);
    tick();
    checks++; if (wd_o !== 32'd5) begin errors++; $display("FAIL branch_x1: got %h expected 5", wd_o); end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd1, 3'd0);
    #1;
    checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL branch_zero: got %b expected 1", zero_o); end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 3'd0, 3'd2);
    #1;
    checks++; if (a_o !== 32'h0001_0000 || zero_o !== 1'b0) begin errors++; $display("FAIL branch_target: got %h z=%b expected 00010000 z=0", a_o, zero_o); end
  endtask

  task automatic test_slt();
    fetch(32'hFFF0_0113);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 3'd0);
    tick();
    fetch(32'h0011_21B3);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd5, 3'd0);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'd1) begin errors++; $display("FAIL slt_neg_lt_pos: got %h expected 1", a_o); end
    fetch(32'h0020_A1B3);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd5, 3'd0);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== 32'd0) begin errors++; $display("FAIL slt_pos_lt_neg: got %h expected 0", a_o); end
  endtask

  task automatic test_lui();
    fetch(32'h1234_50B7);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 3'd0, 3'd4);
    #1;
    checks++; if (a_o !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm: got %h expected 12345000", a_o); end
    tick();
    fetch(32'hFE10_8CE3);
    tick();
    checks++; if (wd_o !== 32'h1234_5000) begin errors++; $display("FAIL lui_x1: got %h expected 12345000", wd_o); end
`ifdef UCSBECE154A_RF_DEBUG_EN
    dbg_addr = 5'd1;
    #1;
    checks++; if (dbg_data !== 32'h1234_5000) begin errors++; $display("FAIL dbg_x1: got %h expected 12345000", dbg_data); end
    dbg_addr = 5'd0;
    #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL dbg_x0: got %h expected 0", dbg_data); end
`endif
  endtask

  task automatic test_reset_mid();
    fetch(32'h1234_50B7);
    reset = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 3'd0);
    tick();
    reset = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    #1;
    checks++; if (a_o !== RST_PC || op_o !== 7'h13 || wd_o !== 32'd0) begin errors++; $display("FAIL midreset_regs: got a=%h op=%h wd=%h expected %h 13 0", a_o, op_o, wd_o, RST_PC); end
    fetch(32'hFE10_8CE3);
    tick();
    checks++; if (wd_o !== 32'h1234_5000) begin errors++; $display("FAIL midreset_nowrite: got %h expected 12345000", wd_o); end
  endtask

  task automatic test_random();
    logic [31:0] alu_v, res_v, adr_v;
    logic [4:0]  r5;
    for (int r = 1; r < 32; r++) begin
      r5 = 5'(r);
      rd_i = {20'($urandom), r5, 7'h37};
      set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 3'd4);
      tick();
    end
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 15) == 0);
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));
      rd_i = $urandom;
      #1;
      if (k >= 3) begin
        ref_eval(alu_v, res_v, adr_v);
        checks++; if (a_o !== adr_v) begin errors++; $display("FAIL rand_addr k=%0d: got %h expected %h", k, a_o, adr_v); end
        checks++; if (wd_o !== m_wd) begin errors++; $display("FAIL rand_wd k=%0d: got %h expected %h", k, wd_o, m_wd); end
        checks++;
        if ({op_o, funct3_o, funct7_o, zero_o} !== {m_instr[6:0], m_instr[14:12], m_instr[30], (alu_v == 32'd0)}) begin
          errors++;
          $display("FAIL rand_decode k=%0d: got op=%h f3=%h f7=%b z=%b expected op=%h f3=%h f7=%b z=%b", k,
                   op_o, funct3_o, funct7_o, zero_o, m_instr[6:0], m_instr[14:12], m_instr[30], (alu_v == 32'd0));
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rd_i = 32'd0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
`ifdef UCSBECE154A_RF_DEBUG_EN
    dbg_addr = 5'd0;
`endif
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = RST_PC; m_oldpc = RST_PC; m_instr = 32'h0000_0013;
    m_data = 32'd0; m_a = 32'd0; m_wd = 32'd0; m_aluout = 32'd0;
    test_reset();
    test_fetch();
    test_addi_x0();
    test_branch();
    test_slt();
    test_lui();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
